multicycle_control: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle combinational opcode decoder with a Moore/Mealy state machine.
- Each instruction is spread over 3-5 clocks, so one ALU and one unified memory port are shared between fetch, address calculation and execute.
- Memory accesses use a ready handshake and are guarded by a watchdog.
- The block drives the mux selects and write enables of PC, IR, register file, ALU and memory.

---
 rtl/mips_pkg.sv | 159 +++++++++++++++
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control_mem_wait_watchdog.sv | 42 ++++
 rtl/multicycle_control.sv | 115 +++++++++++
 tb/tb_multicycle_control.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: sequencer states,
// opcodes, ALU operation codes, datapath mux selects, and the per-state
// control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_HALT
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation, same encoding as alu_control
  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SUB_NOT = 3'b101;
  localparam logic [2:0] ALU_FUNCT   = 3'b111;

  // Datapath mux selects
  localparam logic [1:0] REG_DST_RT    = 2'b00;
  localparam logic [1:0] REG_DST_RD    = 2'b01;
  localparam logic [1:0] REG_DST_RA    = 2'b10;
  localparam logic [1:0] M2R_ALUOUT    = 2'b00;
  localparam logic [1:0] M2R_MDR       = 2'b01;
  localparam logic [1:0] M2R_PC        = 2'b10;
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2  = 2'b11;
  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  // Outputs that depend only on the state (and the latched opcode)
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       bus_error;
  } ctrl_t;

  // ALU operation for the immediate arithmetic/logic group
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI, OP_SLTIU: return ALU_SUB;
      OP_ANDI:           return ALU_AND;
      OP_ORI:            return ALU_OR;
      OP_XORI:           return ALU_XOR;
      default:           return ALU_ADD;
    endcase
  endfunction

  // Control word for a given state; anything not named stays 0
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:    c.alu_src_b = SRCB_IMM_SL2;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_WB_R: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RD;
        c.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = imm_alu_op(op);
      end
      S_WB_I, S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (s == S_MEM_WB) ? M2R_MDR : M2R_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.alu_op        = (op == OP_BNE) ? ALU_SUB_NOT : ALU_SUB;
        c.instr_done    = 1'b1;
      end
      S_JUMP, S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
        if (s == S_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = REG_DST_RA;
          c.mem_to_reg = M2R_PC;
        end
      end
      S_HALT:  c.bus_error = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_control_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, bus_error
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, bus_error
  );
endinterface

// File: rtl/multicycle_control_mem_wait_watchdog.sv
// Memory wait watchdog: counts cycles spent waiting for mem_ready in a
// memory state and flags a timeout when the wait would reach TIMEOUT_CYCLES.
module mem_wait_watchdog #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,     // sequencer is in a memory-wait state
  input  logic clear_i,      // sequencer changes state this cycle
  input  logic mem_ready_i,
  output logic timeout_o
);
  // cnt_q holds the number of unanswered cycles already spent in the state;
  // this cycle is the last allowed one when cnt_q == TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: restart on every state change, advance on each unanswered cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i && !mem_ready_i && cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready on the final cycle still wins over the timeout
  assign timeout_o = active_i && !mem_ready_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer. State-only outputs are registered from the
// next state; ir_write/pc_write in FETCH, the store completion pulse and
// illegal_op are qualified combinationally by mem_ready / opcode.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  state_t state_q, state_d;
  state_t done_next;
  ctrl_t  ctrl_q;
  logic   illegal;
  logic   timeout;
  logic   wait_state;
  logic   fetch_ack;
  logic   store_ack;

  // After an instruction completes, run decides between fetching and idling
  assign done_next  = bus.run ? S_FETCH : S_IDLE;
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                      (state_q == S_MEM_WRITE);

  // Next-state selection
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:      if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout)   state_d = S_HALT;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:                     state_d = S_EXEC_R;
          OP_LB, OP_LW, OP_SB, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:               state_d = S_BRANCH;
          OP_J:                         state_d = S_JUMP;
          OP_JAL:                       state_d = S_JAL;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI:     state_d = S_EXEC_I;
          default: begin
            illegal = 1'b1;
            state_d = done_next;
          end
        endcase
      end
      S_EXEC_R:    state_d = S_WB_R;
      S_EXEC_I:    state_d = S_WB_I;
      // Loads are 100xxx, stores 101xxx
      S_MEM_ADDR:  state_d = bus.opcode[3] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (bus.mem_ready)  state_d = S_MEM_WB;
        else if (timeout)   state_d = S_HALT;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready)  state_d = done_next;
        else if (timeout)   state_d = S_HALT;
      end
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL: state_d = done_next;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  mem_wait_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .active_i    (wait_state),
    .clear_i     (state_d != state_q),
    .mem_ready_i (bus.mem_ready),
    .timeout_o   (timeout)
  );

  // State register with the state-only control word registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, bus.opcode);
    end
  end

  assign fetch_ack = (state_q == S_FETCH) && bus.mem_ready;
  assign store_ack = (state_q == S_MEM_WRITE) && bus.mem_ready;

  assign bus.pc_write      = ctrl_q.pc_write | fetch_ack;
  assign bus.ir_write      = fetch_ack;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.instr_done    = ctrl_q.instr_done | store_ack | illegal;
  assign bus.illegal_op    = illegal;
  assign bus.bus_error     = ctrl_q.bus_error;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A per-instruction reference
// model builds the expected per-cycle output vectors and the mem_ready /
// opcode drive for each cycle; each test task replays and compares them.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
  } ov_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       q_rdy[$];
  logic [5:0] q_op[$];
  ov_t        q_exp[$];

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(
    .TIMEOUT_CYCLES (15),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic ov_t sample();
    ov_t s;
    s.pc_write      = bus.pc_write;
    s.pc_write_cond = bus.pc_write_cond;
    s.i_or_d        = bus.i_or_d;
    s.mem_read      = bus.mem_read;
    s.mem_write     = bus.mem_write;
    s.ir_write      = bus.ir_write;
    s.reg_dst       = bus.reg_dst;
    s.mem_to_reg    = bus.mem_to_reg;
    s.reg_write     = bus.reg_write;
    s.alu_src_a     = bus.alu_src_a;
    s.alu_src_b     = bus.alu_src_b;
    s.alu_op        = bus.alu_op;
    s.pc_source     = bus.pc_source;
    s.instr_done    = bus.instr_done;
    s.illegal_op    = bus.illegal_op;
    s.bus_error     = bus.bus_error;
    return s;
  endfunction

  function automatic ov_t halted();
    ov_t v;
    v = '0;
    v.bus_error = 1'b1;
    return v;
  endfunction

  task automatic push(input logic rdy, input logic [5:0] op, input ov_t v);
    q_rdy.push_back(rdy);
    q_op.push_back(op);
    q_exp.push_back(v);
  endtask

  task automatic clear_plan();
    q_rdy.delete();
    q_op.delete();
    q_exp.delete();
  endtask

  // Reference model: one instruction, starting in its first fetch cycle.
  // fwait / mwait = unanswered memory cycles before mem_ready rises.
  task automatic plan_instr(input logic [5:0] op, input int fwait, input int mwait);
    ov_t v;
    logic [5:0] junk;
    bit is_mem, is_i;
    is_mem = (op == 6'h20) || (op == 6'h23) || (op == 6'h28) || (op == 6'h2B);
    is_i   = (op >= 6'h08) && (op <= 6'h0E);
    // instruction fetch: PC -> memory, PC+4 through the ALU
    for (int i = 0; i <= fwait; i++) begin
      v = '0;
      v.mem_read  = 1'b1;
      v.alu_src_b = 2'b01;
      if (i == fwait) begin
        v.ir_write = 1'b1;
        v.pc_write = 1'b1;
      end
      junk = 6'($urandom_range(0, 63));
      push(i == fwait, junk, v);
    end
    // decode: branch target into ALUOut
    v = '0;
    v.alu_src_b = 2'b11;
    if (!(op == 6'h00 || is_mem || is_i || op == 6'h02 || op == 6'h03 ||
          op == 6'h04 || op == 6'h05)) begin
      v.illegal_op = 1'b1;
      v.instr_done = 1'b1;
      push(1'($urandom), op, v);
      return;
    end
    push(1'($urandom), op, v);
    if (op == 6'h00) begin
      v = '0; v.alu_src_a = 1'b1; v.alu_op = 3'b111;
      push(1'($urandom), op, v);
      v = '0; v.reg_write = 1'b1; v.reg_dst = 2'b01; v.instr_done = 1'b1;
      push(1'($urandom), op, v);
    end else if (is_i) begin
      v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
      if (op == 6'h0A || op == 6'h0B) v.alu_op = 3'b001;
      else if (op == 6'h0C)           v.alu_op = 3'b010;
      else if (op == 6'h0D)           v.alu_op = 3'b011;
      else if (op == 6'h0E)           v.alu_op = 3'b100;
      else                            v.alu_op = 3'b000;
      push(1'($urandom), op, v);
      v = '0; v.reg_write = 1'b1; v.instr_done = 1'b1;
      push(1'($urandom), op, v);
    end else if (is_mem) begin
      v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
      push(1'($urandom), op, v);
      for (int i = 0; i <= mwait; i++) begin
        v = '0; v.i_or_d = 1'b1;
        if (op == 6'h20 || op == 6'h23) v.mem_read = 1'b1;
        else begin
          v.mem_write  = 1'b1;
          v.instr_done = (i == mwait);
        end
        push(i == mwait, op, v);
      end
      if (op == 6'h20 || op == 6'h23) begin
        v = '0; v.reg_write = 1'b1; v.mem_to_reg = 2'b01; v.instr_done = 1'b1;
        push(1'($urandom), op, v);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      v = '0; v.alu_src_a = 1'b1; v.pc_write_cond = 1'b1; v.pc_source = 2'b01;
      v.alu_op = (op == 6'h05) ? 3'b101 : 3'b001; v.instr_done = 1'b1;
      push(1'($urandom), op, v);
    end else begin
      v = '0; v.pc_write = 1'b1; v.pc_source = 2'b10; v.instr_done = 1'b1;
      if (op == 6'h03) begin
        v.reg_write = 1'b1; v.reg_dst = 2'b10; v.mem_to_reg = 2'b10;
      end
      push(1'($urandom), op, v);
    end
  endtask

  task automatic test_reset();
    ov_t act;
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'h23;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    act = sample(); n_checks++;
    if (act !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required %b", act, ov_t'('0));
    end
    @(posedge clk); #1;
    bus.run = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== '0) begin
        n_fail++; $display("FAIL reset_idle_run0 cyc%0d: got %b required %b", k, act, ov_t'('0));
      end
      @(posedge clk); #1;
    end
    bus.run = 1'b1;
    @(negedge clk);
    act = sample(); n_checks++;
    if (act !== '0) begin
      n_fail++; $display("FAIL reset_idle_run1: got %b required %b", act, ov_t'('0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_b2b();
    ov_t act;
    clear_plan();
    for (int n = 0; n < 3; n++) plan_instr(6'h23, 0, 0);
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = 1'b1; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL lw_back_to_back step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_fetch_wait();
    ov_t act;
    clear_plan();
    plan_instr(6'h00, 3, 0);
    plan_instr(6'h00, 0, 0);
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL rtype_fetch_wait step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    ov_t act;
    clear_plan();
    plan_instr(6'h05, 0, 0);
    plan_instr(6'h03, 1, 0);
    plan_instr(6'h04, 0, 0);
    plan_instr(6'h02, 2, 0);
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL branch_jump step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    ov_t act;
    clear_plan();
    plan_instr(6'h3F, 0, 0);
    plan_instr(6'h10, 1, 0);
    plan_instr(6'h0F, 0, 0);
    plan_instr(6'h08, 0, 0);
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL illegal_op step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog_edge();
    ov_t act;
    clear_plan();
    plan_instr(6'h23, 14, 14);
    plan_instr(6'h2B, 14, 14);
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL ready_at_limit step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    ov_t act;
    logic [5:0] legal [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                               6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h20, 6'h23,
                               6'h28, 6'h2B};
    logic [5:0] op;
    int r, fw, mw;
    clear_plan();
    for (int n = 0; n < 40; n++) begin
      r  = int'($urandom_range(0, 19));
      op = (r < 16) ? legal[r] : 6'($urandom_range(0, 63));
      fw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      plan_instr(op, fw, mw);
    end
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL random_stream step%0d op=%h: got %b required %b", k, q_op[k], act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    ov_t act, v;
    int last;
    clear_plan();
    plan_instr(6'h2B, 0, 14);
    // the 15th cycle of the store also goes unanswered
    last = q_exp.size() - 1;
    q_rdy[last] = 1'b0;
    v = q_exp[last];
    v.instr_done = 1'b0;
    q_exp[last] = v;
    for (int i = 0; i < 6; i++) push(1'b1, 6'h00, halted());
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL store_timeout step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    act = sample(); n_checks++;
    if (act !== '0) begin
      n_fail++; $display("FAIL halt_reset_clear: got %b required %b", act, ov_t'('0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.run = 1'b1;
    @(negedge clk);
    act = sample(); n_checks++;
    if (act !== '0) begin
      n_fail++; $display("FAIL halt_reset_idle: got %b required %b", act, ov_t'('0));
    end
    @(posedge clk); #1;
    clear_plan();
    plan_instr(6'h0D, 0, 0);
    for (int k = 0; k < q_exp.size(); k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL after_halt step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    ov_t act;
    clear_plan();
    plan_instr(6'h28, 0, 6);
    // fetch, decode, address, then two waiting store cycles
    for (int k = 0; k < 5; k++) begin
      bus.mem_ready = q_rdy[k]; bus.opcode = q_op[k];
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== q_exp[k]) begin
        n_fail++; $display("FAIL pre_async_reset step%0d: got %b required %b", k, act, q_exp[k]);
      end
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = sample(); n_checks++;
    if (act !== '0) begin
      n_fail++; $display("FAIL async_reset_immediate: got %b required %b", act, ov_t'('0));
    end
    bus.run = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      act = sample(); n_checks++;
      if (act !== '0) begin
        n_fail++; $display("FAIL idle_after_release cyc%0d: got %b required %b", k, act, ov_t'('0));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.run = 1'b0; bus.opcode = 6'h00; bus.mem_ready = 1'b0;
    test_reset();
    test_load_b2b();
    test_rtype_fetch_wait();
    test_branch_jump();
    test_illegal();
    test_watchdog_edge();
    test_random();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
